timersoc_switch_debounce: RTL and testbench
===========================================

TIMERSOC_SWITCH_DEBOUNCE -- requirements
Module: timersoc_switch_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 2: number of independent switch channels; matches the switch PIO in_port width.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a new level; legal range 1 to 2^20.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port sw_raw, input, WIDTH: asynchronous, bouncing switch pins.
REQ-006 SHALL have port sw_out, output, WIDTH: debounced level; drives the switch PIO in_port.
REQ-007 SHALL have port sw_rise, output, WIDTH: one-cycle pulse per bit on an accepted 0->1 change.
REQ-008 SHALL have port sw_fall, output, WIDTH: one-cycle pulse per bit on an accepted 1->0 change.

Function
REQ-009 SHALL pass each sw_raw bit through a two-flop synchronizer (s1, s2) before any other use.
REQ-010 SHALL keep one counter per bit, sized to hold DEBOUNCE_CYCLES-1, plus one registered stable bit per bit driving sw_out.
REQ-011 SHALL, per bit, be in one of two states: IDLE (s2 == sw_out, counter 0) or PENDING (s2 != sw_out, counter counting).
REQ-012 SHALL, per bit and per edge, clear the counter when s2 == sw_out (PENDING -> IDLE; this is the bounce-reject path).
REQ-013 SHALL, per bit, increment the counter when s2 != sw_out and counter < DEBOUNCE_CYCLES-1.
REQ-014 SHALL, per bit, load sw_out <= s2 and clear the counter when s2 != sw_out and counter == DEBOUNCE_CYCLES-1.
REQ-015 SHALL produce, for a raw level change held steady, an sw_out change exactly DEBOUNCE_CYCLES+2 clk edges after the first edge that samples the new raw level.
REQ-016 SHALL treat any mismatch run shorter than DEBOUNCE_CYCLES cycles as noise: sw_out unchanged, counter restarts from 0 on the next mismatch.
REQ-017 SHALL, with DEBOUNCE_CYCLES == 1, update sw_out on the first mismatch edge, with no counter wrap.
REQ-018 SHALL never wrap the counter; it only counts 0..DEBOUNCE_CYCLES-1.
REQ-019 SHALL assert sw_rise[i]/sw_fall[i] on the same edge sw_out[i] updates, for exactly one cycle, never both together.
REQ-020 SHALL handle all bits independently; simultaneous changes on several bits give simultaneous independent updates and pulses.
REQ-021 SHALL register all outputs, with no combinational path from sw_raw to any output.

Reset
REQ-022 SHALL, on any edge with reset_n == 0, clear s1, s2, all counters, sw_out, sw_rise and sw_fall to 0.
REQ-023 SHALL let reset asserted mid-PENDING abort the pending change, with no pulse generated.
REQ-024 SHALL, after reset release with sw_raw high, treat the high level as a normal change: sw_out rises after DEBOUNCE_CYCLES+2 edges, with a sw_rise pulse.

Configuration
REQ-025 SHALL use the macro TIMERSOC_SWITCH_EDGE_EN to control edge detection.
REQ-026 SHALL, when TIMERSOC_SWITCH_EDGE_EN is defined, implement sw_rise/sw_fall per REQ-019.
REQ-027 SHALL, when TIMERSOC_SWITCH_EDGE_EN is not defined, tie sw_rise and sw_fall to constant 0, with no pulse registers present; all other behaviour stays identical.

Verification (WIDTH=2, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-028 SHALL cover: sw_raw 00->01 held -> sw_out=01 exactly 6 edges after the first sampling edge; sw_rise=01 for one cycle on that edge.
REQ-029 SHALL cover: sw_raw[0] toggles 1,0,1,0 every 2 cycles, then settles at 0 -> sw_out stays 00; no pulses.
REQ-030 SHALL cover: sw_raw 00->11 on the same edge, held -> sw_out=11 on one edge; sw_rise=11 for one cycle; later 11->10 -> sw_fall=01 only.
REQ-031 SHALL cover: sw_raw[1] high for 3 cycles (one short of threshold after sync), then low -> no change; high for 4 cycles -> sw_out[1]=1.
REQ-032 SHALL cover: reset_n low for 1 cycle after 2 mismatch cycles -> all outputs 0; with sw_raw still high, sw_out=1 reached 6 edges after release.
REQ-033 SHALL cover: macro undefined, scenario REQ-028 repeated -> sw_out timing identical; sw_rise and sw_fall constant 00.

Source files
------------

// File: rtl/timersoc_switch_debounce_if.sv
// Switch-channel bundle between the raw pins and the debounced PIO side.
// The slave modport is the debouncer; the master modport drives the pins and observes the results.
interface timersoc_switch_debounce_if #(
   parameter int WIDTH = 2
);
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_out;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;

   modport master (output sw_raw, input sw_out, input sw_rise, input sw_fall);
   modport slave  (input sw_raw, output sw_out, output sw_rise, output sw_fall);
endinterface

// File: rtl/timersoc_switch_debounce.sv
// Per-channel two-flop synchronizer and saturating-run debouncer for mechanical switches.
// Define TIMERSOC_SWITCH_EDGE_EN to build the registered sw_rise/sw_fall pulse outputs.
module timersoc_switch_debounce #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                         clk,
   input  logic                         reset_n,
   timersoc_switch_debounce_if.slave    sw
);

   localparam int            CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1_r;
   logic [WIDTH-1:0] s2_r;
   logic [WIDTH-1:0] out_r;
   logic [CW-1:0]    cnt_r [WIDTH];

   logic [WIDTH-1:0] out_s;
   logic [CW-1:0]    cnt_s [WIDTH];

   // Next-state per channel: a mismatch run restarts from zero whenever the level agrees again.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         out_s[i] = out_r[i];
         cnt_s[i] = {CW{1'b0}};
         if (s2_r[i] == out_r[i]) begin
            cnt_s[i] = {CW{1'b0}};
         end else if (cnt_r[i] == LIMIT) begin
            out_s[i] = s2_r[i];
            cnt_s[i] = {CW{1'b0}};
         end else begin
            cnt_s[i] = cnt_r[i] + CW'(1'b1);
         end
      end
   end

   // Synchronizer, run counters and accepted level.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_r  <= {WIDTH{1'b0}};
         s2_r  <= {WIDTH{1'b0}};
         out_r <= {WIDTH{1'b0}};
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= {CW{1'b0}};
         end
      end else begin
         s1_r  <= sw.sw_raw;
         s2_r  <= s1_r;
         out_r <= out_s;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= cnt_s[i];
         end
      end
   end

   assign sw.sw_out = out_r;

`ifdef TIMERSOC_SWITCH_EDGE_EN
   logic [WIDTH-1:0] rise_r;
   logic [WIDTH-1:0] fall_r;

   // Pulses register on the same edge as the accepted level, so they line up with sw_out.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rise_r <= {WIDTH{1'b0}};
         fall_r <= {WIDTH{1'b0}};
      end else begin
         rise_r <= out_s & ~out_r;
         fall_r <= ~out_s & out_r;
      end
   end

   assign sw.sw_rise = rise_r;
   assign sw.sw_fall = fall_r;
`else
   assign sw.sw_rise = {WIDTH{1'b0}};
   assign sw.sw_fall = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_timersoc_switch_debounce.sv
// Directed and randomized bench for timersoc_switch_debounce (WIDTH=2, DEBOUNCE_CYCLES=4).
module tb_timersoc_switch_debounce;

   localparam int D = 4;
`ifdef TIMERSOC_SWITCH_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   timersoc_switch_debounce_if #(.WIDTH(2)) bus ();

   timersoc_switch_debounce #(.WIDTH(2), .DEBOUNCE_CYCLES(D)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sw      (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference: per-edge history of raw samples; a bit flips once the D samples
   // taken 2..D+1 edges ago all disagree with its current debounced level.
   logic [1:0] hist[$];
   logic [1:0] m_out  = 2'b00;
   logic [1:0] m_rise = 2'b00;
   logic [1:0] m_fall = 2'b00;

   task automatic model_edge(input logic [1:0] raw, input logic rn);
      m_rise = 2'b00;
      m_fall = 2'b00;
      if (!rn) begin
         hist.delete();
         for (int k = 0; k < D + 2; k++) hist.push_back(2'b00);
         m_out = 2'b00;
      end else begin
         hist.push_back(raw);
         if (hist.size() > D + 8) void'(hist.pop_front());
         for (int b = 0; b < 2; b++) begin
            bit flip = 1'b1;
            for (int k = 2; k <= D + 1; k++) begin
               if (hist[hist.size() - 1 - k][b] == m_out[b]) flip = 1'b0;
            end
            if (flip) begin
               m_out[b] = ~m_out[b];
               if (m_out[b]) m_rise[b] = 1'b1;
               else          m_fall[b] = 1'b1;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, advance model at posedge, compare 1 time unit later.
   task automatic step(input logic [1:0] raw, input logic rn);
      @(negedge clk);
      bus.sw_raw = raw;
      reset_n    = rn;
      @(posedge clk);
      model_edge(raw, rn);
      #1;
      chk("sw_out",  bus.sw_out,  m_out);
      chk("sw_rise", bus.sw_rise, EDGE ? m_rise : 2'b00);
      chk("sw_fall", bus.sw_fall, EDGE ? m_fall : 2'b00);
   endtask

   task automatic hold(input logic [1:0] raw, input int n);
      for (int k = 0; k < n; k++) step(raw, 1'b1);
   endtask

   initial begin
      logic [1:0] lvl;
      int         len;
      bus.sw_raw = 2'b00;

      // Reset state
      step(2'b00, 1'b0);
      step(2'b00, 1'b0);
      chk("reset_out", bus.sw_out, 2'b00);

      // 00->01 held: accepted on the 6th edge with a single rise pulse
      hold(2'b01, 5);
      chk("s1_out_e5", bus.sw_out, 2'b00);
      step(2'b01, 1'b1);
      chk("s1_out_e6", bus.sw_out, 2'b01);
      chk("s1_rise_e6", bus.sw_rise, EDGE ? 2'b01 : 2'b00);
      step(2'b01, 1'b1);
      chk("s1_rise_e7", bus.sw_rise, 2'b00);
      hold(2'b00, 8);
      chk("s1_back", bus.sw_out, 2'b00);

      // Bit 0 bouncing every 2 cycles, then settling low: no change
      hold(2'b01, 2); hold(2'b00, 2); hold(2'b01, 2); hold(2'b00, 2);
      hold(2'b00, 8);
      chk("s2_bounce", bus.sw_out, 2'b00);

      // Both bits together, then bit 0 alone falls
      hold(2'b11, 5);
      step(2'b11, 1'b1);
      chk("s3_out", bus.sw_out, 2'b11);
      chk("s3_rise", bus.sw_rise, EDGE ? 2'b11 : 2'b00);
      hold(2'b11, 3);
      hold(2'b10, 5);
      step(2'b10, 1'b1);
      chk("s3_out_fall", bus.sw_out, 2'b10);
      chk("s3_fall", bus.sw_fall, EDGE ? 2'b01 : 2'b00);
      hold(2'b00, 10);

      // Bit 1 high one cycle short, then exactly at threshold
      hold(2'b10, 3);
      hold(2'b00, 8);
      chk("s4_short", bus.sw_out, 2'b00);
      hold(2'b10, 4);
      hold(2'b00, 2);
      chk("s4_exact", bus.sw_out, 2'b10);
      hold(2'b00, 10);

      // Reset mid-pending, raw still high: restart as a normal change
      hold(2'b11, 4);
      step(2'b11, 1'b0);
      chk("s5_rst_out", bus.sw_out, 2'b00);
      chk("s5_rst_rise", bus.sw_rise, 2'b00);
      hold(2'b11, 5);
      chk("s5_e5", bus.sw_out, 2'b00);
      step(2'b11, 1'b1);
      chk("s5_e6", bus.sw_out, 2'b11);
      chk("s5_rise", bus.sw_rise, EDGE ? 2'b11 : 2'b00);

      // Randomized runs of bouncing levels with occasional resets
      for (int n = 0; n < 300; n++) begin
         lvl = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 8);
         if ($urandom_range(0, 40) == 0) step(lvl, 1'b0);
         else hold(lvl, len);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
